// File: rtl/xpmwrap_pkg.sv
// Shared constants for the xpmwrap FIFO controller and its storage RAM.
package xpmwrap_pkg;

  localparam int unsigned OBUF_DEPTH     = 3;
  localparam int unsigned OBUF_CNT_W     = 2;
  localparam int unsigned RAM_RD_LATENCY = 2;

endpackage

// File: rtl/xpmwrap_sdpram.sv
// Simple dual-port RAM, common clock, two-cycle read latency (array read
// register followed by a regce-gated output register), rstb clears the read pipe.
module xpmwrap_sdpram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic                  rstb,
  input  logic                  regceb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (ena && wea) begin
      mem_q[addra] <= dina;
    end
  end

  always_comb begin
    rd_d   = rd_q;
    dout_d = dout_q;
    if (enb) begin
      rd_d = mem_q[addrb];
    end
    if (regceb) begin
      dout_d = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  assign doutb = dout_q;

endmodule

// File: rtl/xpmwrap_fifo_ctrl.sv
// FIFO controller around a 2-cycle-latency SDP RAM with a 3-entry output buffer.
// Optional prog_full watermark enabled by defining XPMWRAP_FIFO_WATERMARK_EN.
module xpmwrap_fifo_ctrl
  import xpmwrap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 6,
  parameter int unsigned PROG_FULL_THRESH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  prog_full
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 16 ||
      PROG_FULL_THRESH > DEPTH + OBUF_DEPTH) begin : g_param_check
    $error("xpmwrap_fifo_ctrl: illegal parameter set");
  end

  logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          ram_cnt_q, ram_cnt_d;
  logic [RAM_RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [OBUF_CNT_W-1:0]     obuf_cnt_q, obuf_cnt_d;
  logic [DATA_WIDTH-1:0]     obuf_q [OBUF_DEPTH];
  logic [DATA_WIDTH-1:0]     obuf_d [OBUF_DEPTH];
  logic [CNT_W-1:0]          level_q, level_d;
  logic                      m_valid_q, m_valid_d;
  logic                      s_ready_q, s_ready_d;

  logic                      wr_fire;
  logic                      pop;
  logic                      push;
  logic                      rd_issue;
  logic [2:0]                occ;
  logic [DATA_WIDTH-1:0]     ram_dout;

  assign s_ready = s_ready_q && !rst;
  assign wr_fire = s_valid && s_ready;
  assign pop     = m_valid_q && m_ready && !rst;
  assign push    = inflight_q[RAM_RD_LATENCY-1];

  // The word leaving on a pop frees its slot this cycle, which keeps a steady
  // stream at one word per clock while still capping buffer+pipe at three.
  always_comb begin
    occ      = 3'(inflight_q[0]) + 3'(inflight_q[1]) + 3'(obuf_cnt_q) - 3'(pop);
    rd_issue = !rst && (ram_cnt_q != '0) && (occ < 3'(OBUF_DEPTH));
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    level_d    = level_q;
    inflight_d = {inflight_q[RAM_RD_LATENCY-2:0], rd_issue};
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({wr_fire, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
    case ({wr_fire, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
    s_ready_d = ram_cnt_d < CNT_W'(DEPTH);
  end

  // Output buffer keeps the head in entry 0 so m_data comes straight from a flop.
  always_comb begin
    obuf_d     = obuf_q;
    obuf_cnt_d = obuf_cnt_q;
    if (pop) begin
      for (int unsigned i = 0; i < OBUF_DEPTH - 1; i++) begin
        obuf_d[i] = obuf_q[i+1];
      end
      obuf_cnt_d = obuf_cnt_q - OBUF_CNT_W'(1);
    end
    if (push) begin
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        if (obuf_cnt_d == OBUF_CNT_W'(i)) begin
          obuf_d[i] = ram_dout;
        end
      end
      obuf_cnt_d = obuf_cnt_d + OBUF_CNT_W'(1);
    end
    m_valid_d = obuf_cnt_d != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= '0;
      obuf_cnt_q <= '0;
      level_q    <= '0;
      m_valid_q  <= 1'b0;
      s_ready_q  <= 1'b1;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        obuf_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      level_q    <= level_d;
      m_valid_q  <= m_valid_d;
      s_ready_q  <= s_ready_d;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        obuf_q[i] <= obuf_d[i];
      end
    end
  end

  assign m_data  = obuf_q[0];
  assign m_valid = m_valid_q;
  assign level   = level_q;

`ifdef XPMWRAP_FIFO_WATERMARK_EN
  logic prog_full_q, prog_full_d;

  always_comb begin
    prog_full_d = 32'(level_d) >= PROG_FULL_THRESH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_full_q <= 1'b0;
    end else begin
      prog_full_q <= prog_full_d;
    end
  end

  assign prog_full = prog_full_q;
`else
  assign prog_full = 1'b0;
`endif

  xpmwrap_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .ena    (wr_fire),
    .wea    (wr_fire),
    .addra  (wr_ptr_q),
    .dina   (s_data),
    .enb    (rd_issue),
    .rstb   (rst),
    .regceb (1'b1),
    .addrb  (rd_ptr_q),
    .doutb  (ram_dout)
  );

endmodule
